// File: rtl/inv_factorial_pkg.sv
// Shared constants and state encoding for the inverse-factorial decoder.
// The data width matches the output width of the factorial generator.
package inv_factorial_pkg;

  localparam int DATA_W = 46;
  localparam int N_W    = 5;
  localparam int PROD_W = 51;
  localparam int K_MAX  = 16;

  localparam logic [DATA_W-1:0] FACT_16 = 46'd20922789888000;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

endpackage

// File: rtl/inv_factorial_blk.sv
// Inverse-factorial decoder: returns the largest n in 1..16 with n! <= X.
// One multiply-and-compare step per clock, with valid/ready on both sides.
module inv_factorial_blk
  import inv_factorial_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_W-1:0]    out_n,
  output logic              out_exact,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_busy
);

  state_t            state;
  logic [DATA_W-1:0] x_reg;
  logic [DATA_W-1:0] acc;
  logic [N_W-1:0]    k;
  logic              zero_f;

  logic [N_W-1:0]    k_inc;
  logic [PROD_W-1:0] nxt;
  logic              stop;

  // Full-width product: acc*(k+1) can reach 17! while searching past 16!.
  always_comb begin
    k_inc = k + 5'd1;
    nxt   = {{(PROD_W-DATA_W){1'b0}}, acc} * {{(PROD_W-N_W){1'b0}}, k_inc};
    stop  = zero_f || (k == N_W'(K_MAX)) || (nxt > {{(PROD_W-DATA_W){1'b0}}, x_reg});
  end

  assign in_ready = (state == IDLE);
  assign out_busy = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      x_reg     <= '0;
      acc       <= DATA_W'(1);
      k         <= N_W'(1);
      zero_f    <= 1'b0;
      out_n     <= '0;
      out_exact <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg  <= in_data;
            acc    <= DATA_W'(1);
            k      <= N_W'(1);
            zero_f <= (in_data == '0);
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (stop) begin
            out_valid <= 1'b1;
            state     <= DONE;
            if (zero_f) begin
              out_n     <= '0;
              out_exact <= 1'b0;
              out_err   <= 1'b1;
            end else begin
              out_n     <= k;
              out_exact <= (acc == x_reg);
              out_err   <= 1'b0;
            end
          end else begin
            // acc stays at or below 16!, so dropping the top bits is lossless.
            acc <= nxt[DATA_W-1:0];
            k   <= k_inc;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_factorial_blk.sv
// Scoreboard bench for inv_factorial_blk: the driver pushes model results,
// an independent monitor pops and compares each time out_valid rises.
module tb_inv_factorial_blk;
  import inv_factorial_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_W-1:0]    out_n;
  logic              out_exact;
  logic              out_err;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_busy;

  inv_factorial_blk dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_n    (out_n),
    .out_exact(out_exact),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_busy (out_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     n;
    bit     exact;
    bit     err;
    int     lat;
    longint acc_cyc;
    longint x;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     bp_force = 1'b0;
  bit     rand_bp = 1'b0;
  bit     prev_valid = 1'b0;

  localparam longint MAX_X = (longint'(1) << 46) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic longint fact(input int n);
    longint f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Reference: scan n = 16 down to 1 for the first factorial not above x.
  function automatic exp_t model(input longint x);
    exp_t e;
    e.x = x;
    e.n = 0;
    e.exact = 1'b0;
    e.err = (x == 0);
    if (x != 0) begin
      for (int n = 16; n >= 1; n--) begin
        if (fact(n) <= x) begin
          e.n = n;
          break;
        end
      end
      e.exact = (fact(e.n) == x);
    end
    e.lat = (e.n > 1) ? e.n : 1;
    return e;
  endfunction

  always @(negedge clk) begin
    out_ready = bp_force ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: one result per rising out_valid.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: out_valid rose with no pending input (cycle %0d, out_n %0d)", cyc, out_n);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("out_n x=%0d", e.x), longint'(out_n), longint'(e.n));
          check($sformatf("out_exact x=%0d", e.x), longint'(out_exact), longint'(e.exact));
          check($sformatf("out_err x=%0d", e.x), longint'(out_err), longint'(e.err));
          check($sformatf("latency x=%0d", e.x), cyc - e.acc_cyc, longint'(e.lat));
          check($sformatf("busy_in_done x=%0d", e.x), longint'(out_busy), 1);
        end
      end
      prev_valid = out_valid;
    end
  end

  // Presents x at a negedge and returns after the accepting edge.
  task automatic send(input longint x, input bit expect_result);
    int   budget = 200;
    exp_t e;
    @(negedge clk);
    in_data  = DATA_W'(x);
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("in_ready_timeout", longint'(in_ready), 1);
    end else begin
      e = model(x);
      e.acc_cyc = cyc + 1;
      if (expect_result) sb.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    int budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_pending", longint'(sb.size()), 0);
  endtask

  initial begin
    longint x;
    int     n;

    // Reset state
    #12;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_busy", longint'(out_busy), 0);
    check("rst_out_n", longint'(out_n), 0);
    check("rst_out_exact", longint'(out_exact), 0);
    check("rst_out_err", longint'(out_err), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed corners
    send(120, 1'b1);
    send(121, 1'b1);
    send(0, 1'b1);
    send(1, 1'b1);
    send(longint'(FACT_16), 1'b1);
    send(MAX_X, 1'b1);
    send(2, 1'b1);
    send(longint'(FACT_16) - 1, 1'b1);
    drain();

    // Backpressure: DONE must hold with outputs frozen and input ignored.
    bp_force = 1'b1;
    @(negedge clk);
    send(720, 1'b1);
    begin
      int budget = 50;
      while (!out_valid && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("bp_valid_seen", longint'(out_valid), 1);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_data  = DATA_W'(24);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      check($sformatf("bp_valid[%0d]", i), longint'(out_valid), 1);
      check($sformatf("bp_in_ready[%0d]", i), longint'(in_ready), 0);
      check($sformatf("bp_out_n[%0d]", i), longint'(out_n), 6);
      check($sformatf("bp_exact[%0d]", i), longint'(out_exact), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    bp_force = 1'b0;
    send(24, 1'b1);
    drain();

    // Reset mid-search: the in-flight result must vanish.
    send(3628800, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_out_busy", longint'(out_busy), 0);
    check("midrst_out_n", longint'(out_n), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_valid", longint'(out_valid), 0);
    send(6, 1'b1);
    drain();

    // Round trip against factorials 1!..15!
    for (int k = 1; k <= 15; k++) send(fact(k), 1'b1);
    drain();

    // Randomized values clustered around factorial boundaries, random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(1, 16);
      case ($urandom_range(0, 4))
        0:       x = fact(n);
        1:       x = fact(n) - 1;
        2:       x = fact(n) + 1;
        3:       x = fact(n) + longint'($urandom()) % fact(n);
        default: x = longint'(46'({$urandom(), $urandom()}));
      endcase
      if (x > MAX_X) x = MAX_X;
      send(x, 1'b1);
    end
    drain();
    rand_bp = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
